md_stall_ctrl: RTL and testbench
================================

// Module: md_stall_ctrl
// PURPOSE
//  Sequences the multi-cycle multiply/divide unit added beside the E stage of the five-stage pipeline.
//  Tracks MDU occupancy with a latency counter and pulses the HI/LO write strobe on completion.
//  Merges MDU stalls with the existing Tuse/Tnew hazard stall into the pipeline enables enPC, enD and clrE.
//  Keeps a saturating stall-cycle counter for performance checks.
// PARAMETERS
//  MULT_LAT  5   cycles busy for mult/multu (must be >= 1)
//  DIV_LAT   10  cycles busy for div/divu (must be >= 1)
//  CNT_W     4   latency counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT)
//  PERF_W    32  stall counter width
// PORTS
//  clk          in   1       system clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  start_mult   in   1       E-stage instr is mult/multu this cycle (valid, not bubble)
//  start_div    in   1       E-stage instr is div/divu this cycle
//  md_use_D     in   1       D-stage instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
//  hazard_stall in   1       stall request from Tuse/Tnew data-hazard logic
//  enPC         out  1       PC write enable
//  enD          out  1       D pipeline register enable
//  clrE         out  1       E pipeline register synchronous clear (bubble insert)
//  busy         out  1       MDU occupied (registered)
//  hilo_we      out  1       one-cycle strobe: MDU result valid, write HI/LO
//  md_err       out  1       sticky: start while busy, or mult and div started together
//  stall_cnt    out  PERF_W  count of cycles with stall asserted, saturating
// BEHAVIOUR
//  Reset (reset==0, async)
//   - State -> IDLE; cnt, busy, hilo_we, md_err and stall_cnt -> 0.
//   - enPC/enD = 1 and clrE = 0 whenever reset is asserted, regardless of the other inputs.
//   - Reset during BUSY aborts the operation; no hilo_we is issued.
//  FSM: IDLE, BUSY.
//   - IDLE:
//     - start_div -> BUSY, cnt = DIV_LAT.
//     - else start_mult -> BUSY, cnt = MULT_LAT.
//     - Both asserted -> div wins and md_err is set.
//   - BUSY:
//     - cnt decrements by 1 each cycle.
//     - When cnt==1: next state IDLE, and hilo_we is registered high for exactly one cycle.
//     - Any start_* while BUSY is ignored and sets md_err.
//  Timing: start sampled at edge t.
//   - busy is 1 on cycles t+1 .. t+LAT.
//   - hilo_we is 1 on cycle t+LAT+1.
//   - busy is 0 on t+LAT+1.
//   - A new start at t+LAT+1 is legal and re-enters BUSY with no idle gap.
//  busy=1 exactly when state==BUSY; cnt never wraps (load only from IDLE).
//  Stall (combinational, outside reset):
//   - md_stall = md_use_D & (busy | start_mult | start_div).
//   - stall = hazard_stall | md_stall.
//   - enPC = ~stall; enD = ~stall; clrE = stall.
//  stall_cnt: +1 on each edge where stall==1 (sampled while reset deasserted); holds at 2^PERF_W-1.
//  md_err clears only on reset.
// TESTING
//  1. Reset: assert reset for 3 cycles, inputs 0 -> busy=0, hilo_we=0, enPC=enD=1, clrE=0, stall_cnt=0.
//  2. mult, no dependants: start_mult for 1 cycle at t ->
//     - busy high for exactly 5 cycles (t+1..t+5);
//     - hilo_we single pulse at t+6;
//     - enPC stays 1 throughout.
//  3. div then mflo: start_div at t, md_use_D=1 from t onward ->
//     - stall=1 (enPC=enD=0, clrE=1) for cycles t..t+10;
//     - enPC=1 at t+11;
//     - stall_cnt=11.
//  4. Hazard merge: hazard_stall=1 with MDU idle -> clrE=1, enD=0.
//     Then start_mult and start_div together -> md_err=1, busy lasts 10 cycles.
//  5. Back-to-back: second start_mult on hilo_we cycle -> busy re-rises next cycle, no md_err;
//     start during BUSY -> md_err=1, latency unchanged.
//  6. Abort: reset mid-BUSY (cnt=3) -> busy=0 immediately, no hilo_we after release;
//     saturation: force PERF_W=4, stall 20 cycles -> stall_cnt=15.

Source files
------------

// File: rtl/md_stall_if.sv
// -----------------------------------------------------------------------------
// md_stall_if
//   Handshake bundle between the pipeline (E/D stage decode and hazard logic)
//   and the multiply/divide stall controller.
//
//   Pipeline -> controller:
//     start_mult    E-stage instruction is mult/multu (valid, not a bubble)
//     start_div     E-stage instruction is div/divu
//     md_use_D      D-stage instruction touches the MDU or HI/LO
//     hazard_stall  stall request from the Tuse/Tnew data-hazard logic
//   Controller -> pipeline:
//     enPC, enD     PC and D-register write enables
//     clrE          E-register synchronous clear (bubble insert)
//     busy          MDU occupied
//     hilo_we       one-cycle HI/LO write strobe on completion
//     md_err        sticky misuse flag
//     stall_cnt     saturating count of stalled cycles
//
//   master: the pipeline side.  slave: the stall controller.
// -----------------------------------------------------------------------------
interface md_stall_if #(
  parameter int PERF_W = 32
);
  logic              start_mult;
  logic              start_div;
  logic              md_use_D;
  logic              hazard_stall;
  logic              enPC;
  logic              enD;
  logic              clrE;
  logic              busy;
  logic              hilo_we;
  logic              md_err;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output start_mult,
    output start_div,
    output md_use_D,
    output hazard_stall,
    input  enPC,
    input  enD,
    input  clrE,
    input  busy,
    input  hilo_we,
    input  md_err,
    input  stall_cnt
  );

  modport slave (
    input  start_mult,
    input  start_div,
    input  md_use_D,
    input  hazard_stall,
    output enPC,
    output enD,
    output clrE,
    output busy,
    output hilo_we,
    output md_err,
    output stall_cnt
  );
endinterface

// File: rtl/md_stall_ctrl.sv
// -----------------------------------------------------------------------------
// md_stall_ctrl
//   Sequences the multi-cycle multiply/divide unit that sits beside the E
//   stage. A latency counter tracks occupancy; when it expires a one-cycle
//   HI/LO write strobe is issued. MDU stalls are merged with the Tuse/Tnew
//   hazard stall to produce the pipeline enables, and stalled cycles are
//   counted in a saturating performance counter.
//
// Parameters
//   MULT_LAT  busy cycles for mult/multu (>= 1)
//   DIV_LAT   busy cycles for div/divu   (>= 1)
//   CNT_W     latency counter width, 2**CNT_W > max(MULT_LAT, DIV_LAT)
//   PERF_W    stall counter width (must match the interface PERF_W)
//
// Ports
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   md     md_stall_if.slave: start_mult, start_div, md_use_D, hazard_stall in;
//          enPC, enD, clrE, busy, hilo_we, md_err, stall_cnt out
// -----------------------------------------------------------------------------
module md_stall_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4,
  parameter int PERF_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  md_stall_if.slave   md
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               hilo_we_q;
  logic               hilo_we_d;
  logic               md_err_q;
  logic               md_err_d;
  logic [PERF_W-1:0]  stall_cnt_q;

  logic               busy;
  logic               start_any;
  logic               md_stall;
  logic               stall;
  logic               stall_out;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    logic [PERF_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + PERF_W'(1);
    end
    return r;
  endfunction

  assign busy      = (state_q == BUSY);
  assign start_any = md.start_mult | md.start_div;

  // ---------------------------------------------------------------------------
  // FSM next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hilo_we_d = 1'b0;
    md_err_d  = md_err_q;

    case (state_q)
      IDLE: begin
        // div has priority; issuing both together is a decode error
        if (md.start_div) begin
          state_d = BUSY;
          cnt_d   = DIV_LD;
          if (md.start_mult) begin
            md_err_d = 1'b1;
          end
        end else if (md.start_mult) begin
          state_d = BUSY;
          cnt_d   = MULT_LD;
        end
      end

      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        // A start while occupied is dropped; latency of the running op holds.
        if (start_any) begin
          md_err_d = 1'b1;
        end
        // Last busy cycle: result lands next cycle, and IDLE there lets a
        // dependent start re-enter BUSY with no gap.
        if (cnt_q == CNT_ONE) begin
          state_d   = IDLE;
          hilo_we_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hilo_we_q <= 1'b0;
      md_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hilo_we_q <= hilo_we_d;
      md_err_q  <= md_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall merge
  // ---------------------------------------------------------------------------
  // The D-stage MDU consumer must wait both while the unit is occupied and in
  // the cycle the E-stage op is being launched (busy is not yet visible).
  assign md_stall  = md.md_use_D & (busy | start_any);
  assign stall     = md.hazard_stall | md_stall;
  // While reset is held the pipeline must free-run, whatever the inputs say.
  assign stall_out = stall & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign md.enPC      = ~stall_out;
  assign md.enD       = ~stall_out;
  assign md.clrE      = stall_out;
  assign md.busy      = busy;
  assign md.hilo_we   = hilo_we_q;
  assign md.md_err    = md_err_q;
  assign md.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_md_stall_ctrl.sv
module tb_md_stall_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  md_stall_if #(.PERF_W(32)) md ();
  md_stall_if #(.PERF_W(4))  md2 ();

  // Second instance (4-bit stall counter) sees identical stimulus.
  assign md2.start_mult   = md.start_mult;
  assign md2.start_div    = md.start_div;
  assign md2.md_use_D     = md.md_use_D;
  assign md2.hazard_stall = md.hazard_stall;

  md_stall_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4), .PERF_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  md_stall_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4), .PERF_W(4)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .md    (md2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and land just after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    md.start_mult   = 1'b0;
    md.start_div    = 1'b0;
    md.md_use_D     = 1'b0;
    md.hazard_stall = 1'b0;
  endtask

  initial begin
    int seen_hilo;
    int seen_busy;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    clr_inputs();

    // ---- 1. reset ----
    cyc(1);
    md.hazard_stall = 1'b1;
    md.md_use_D     = 1'b1;
    md.start_div    = 1'b1;
    #1;
    check("rst_enPC_forced", 32'(md.enPC), 32'd1);
    check("rst_clrE_forced", 32'(md.clrE), 32'd0);
    clr_inputs();
    cyc(2);
    reset = 1'b1;
    #1;
    check("rst_busy",    32'(md.busy),      32'd0);
    check("rst_hilo",    32'(md.hilo_we),   32'd0);
    check("rst_enPC",    32'(md.enPC),      32'd1);
    check("rst_enD",     32'(md.enD),       32'd1);
    check("rst_clrE",    32'(md.clrE),      32'd0);
    check("rst_stallcnt", md.stall_cnt,     32'd0);
    check("rst_err",     32'(md.md_err),    32'd0);

    // ---- 2. mult, no dependants ----
    cyc(1);
    md.start_mult = 1'b1;
    #1;
    check("mult_enPC_t0", 32'(md.enPC), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      md.start_mult = 1'b0;
      #1;
      check($sformatf("mult_busy_t%0d", k), 32'(md.busy),    32'(k <= 5));
      check($sformatf("mult_hilo_t%0d", k), 32'(md.hilo_we), 32'(k == 6));
      check($sformatf("mult_enPC_t%0d", k), 32'(md.enPC),    32'd1);
    end
    cyc(1);
    check("mult_hilo_t7", 32'(md.hilo_we), 32'd0);
    check("mult_err",     32'(md.md_err),  32'd0);
    check("mult_stallcnt", md.stall_cnt,   32'd0);

    // ---- 3. div then mflo ----
    cyc(1);
    md.start_div = 1'b1;
    md.md_use_D  = 1'b1;
    #1;
    check("div_enPC_t0", 32'(md.enPC), 32'd0);
    check("div_enD_t0",  32'(md.enD),  32'd0);
    check("div_clrE_t0", 32'(md.clrE), 32'd1);
    for (int k = 1; k <= 11; k++) begin
      cyc(1);
      md.start_div = 1'b0;
      #1;
      check($sformatf("div_enPC_t%0d", k), 32'(md.enPC), 32'(k == 11));
      check($sformatf("div_clrE_t%0d", k), 32'(md.clrE), 32'(k != 11));
    end
    check("div_stallcnt", md.stall_cnt,   32'd11);
    check("div_hilo",     32'(md.hilo_we), 32'd1);
    check("div_busy_end", 32'(md.busy),    32'd0);
    md.md_use_D = 1'b0;

    // ---- 4. hazard merge, then double start ----
    cyc(1);
    md.hazard_stall = 1'b1;
    #1;
    check("haz_clrE", 32'(md.clrE), 32'd1);
    check("haz_enD",  32'(md.enD),  32'd0);
    check("haz_busy", 32'(md.busy), 32'd0);
    cyc(1);
    md.hazard_stall = 1'b0;
    md.start_mult   = 1'b1;
    md.start_div    = 1'b1;
    #1;
    check("haz_stallcnt", md.stall_cnt,  32'd12);
    check("both_clrE",    32'(md.clrE), 32'd0);
    seen_busy = 0;
    for (int k = 1; k <= 11; k++) begin
      cyc(1);
      md.start_mult = 1'b0;
      md.start_div  = 1'b0;
      #1;
      if (md.busy === 1'b1) seen_busy++;
      if (k == 11) check("both_hilo", 32'(md.hilo_we), 32'd1);
    end
    check("both_busy_len", 32'(seen_busy),   32'd10);
    check("both_err",      32'(md.md_err),   32'd1);

    // clear sticky md_err with a short async pulse
    reset = 1'b0;
    #2;
    check("err_cleared", 32'(md.md_err), 32'd0);
    reset = 1'b1;

    // ---- 5. back-to-back and start while busy ----
    cyc(1);
    md.start_mult = 1'b1;
    cyc(1);
    md.start_mult = 1'b0;
    cyc(5);
    #1;
    check("b2b_hilo_t6", 32'(md.hilo_we), 32'd1);
    check("b2b_busy_t6", 32'(md.busy),    32'd0);
    md.start_mult = 1'b1;
    cyc(1);
    md.start_mult = 1'b0;
    #1;
    check("b2b_busy_t7", 32'(md.busy),    32'd1);
    check("b2b_err_t7",  32'(md.md_err),  32'd0);
    cyc(1);
    md.start_mult = 1'b1;
    cyc(1);
    md.start_mult = 1'b0;
    #1;
    check("inbusy_err",  32'(md.md_err),  32'd1);
    check("inbusy_busy", 32'(md.busy),    32'd1);
    cyc(2);
    check("inbusy_busy_t11", 32'(md.busy),    32'd1);
    check("inbusy_hilo_t11", 32'(md.hilo_we), 32'd0);
    cyc(1);
    check("inbusy_hilo_t12", 32'(md.hilo_we), 32'd1);
    check("inbusy_busy_t12", 32'(md.busy),    32'd0);

    // ---- 6. abort mid-BUSY ----
    cyc(1);
    md.start_div = 1'b1;
    cyc(1);
    md.start_div = 1'b0;
    cyc(7);
    check("abort_busy_pre", 32'(md.busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busy",  32'(md.busy),    32'd0);
    check("abort_err",   32'(md.md_err),  32'd0);
    check("abort_enPC",  32'(md.enPC),    32'd1);
    cyc(1);
    reset = 1'b1;
    seen_hilo = 0;
    seen_busy = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      if (md.hilo_we === 1'b1) seen_hilo++;
      if (md.busy === 1'b1) seen_busy++;
    end
    check("abort_no_hilo", 32'(seen_hilo), 32'd0);
    check("abort_no_busy", 32'(seen_busy), 32'd0);

    // ---- saturation (4-bit counter instance) ----
    check("sat_start", 32'(md2.stall_cnt), 32'd0);
    md.hazard_stall = 1'b1;
    cyc(15);
    check("sat_cnt15_w4",  32'(md2.stall_cnt), 32'd15);
    check("sat_cnt15_w32", md.stall_cnt,       32'd15);
    cyc(1);
    check("sat_hold_w4",   32'(md2.stall_cnt), 32'd15);
    check("sat_cnt16_w32", md.stall_cnt,       32'd16);
    cyc(4);
    md.hazard_stall = 1'b0;
    #1;
    check("sat_cnt20_w4",  32'(md2.stall_cnt), 32'd15);
    check("sat_cnt20_w32", md.stall_cnt,       32'd20);
    check("sat_w4_enPC",   32'(md2.enPC),      32'd1);
    check("sat_w4_enD",    32'(md2.enD),       32'd1);
    check("sat_w4_clrE",   32'(md2.clrE),      32'd0);
    check("sat_w4_busy",   32'(md2.busy),      32'd0);
    check("sat_w4_hilo",   32'(md2.hilo_we),   32'd0);
    check("sat_w4_err",    32'(md2.md_err),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
